// File: rtl/display_pkg.sv
// Shared types for the multiplexed 7-segment scan controller.
package display_pkg;

  typedef enum logic {BLANK = 1'b0, SHOW = 1'b1} scan_state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Producer-side bus of the scan controller: value load, enable and digit drive outputs.
interface display_scan_ctrl_if #(parameter int DIGITS = 4);
  logic                  en_i;
  logic                  load_i;
  logic [4*DIGITS-1:0]   value_i;
  logic [3:0]            cuenta_o;
  logic [DIGITS-1:0]     digit_en_o;
  logic                  frame_o;
  logic                  pending_o;

  modport master (output en_i, load_i, value_i,
                  input  cuenta_o, digit_en_o, frame_o, pending_o);
  modport slave  (input  en_i, load_i, value_i,
                  output cuenta_o, digit_en_o, frame_o, pending_o);
endinterface

// File: rtl/display_slot_timer.sv
// Slot sequencer: counts PRESCALE cycles per digit, BLANK for the first BLANK_CYCLES, then SHOW.
module display_slot_timer
  import display_pkg::*;
#(
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic blank_end_o,
  output logic slot_end_o,
  output logic slot_last_o
);
  localparam int CW = idx_w(PRESCALE);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SLOT_LAST  = CW'(PRESCALE - 1);

  scan_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    blank_end_o = 1'b0;
    slot_end_o  = 1'b0;
    if (!en_i) begin
      state_d = BLANK;
      cnt_d   = '0;
    end else if (state_q == BLANK) begin
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == BLANK_LAST) begin
        state_d     = SHOW;
        blank_end_o = 1'b1;
      end
    end else if (cnt_q == SLOT_LAST) begin
      cnt_d      = '0;
      state_d    = BLANK;
      slot_end_o = 1'b1;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
    // Lookahead so the parent can register a pulse aligned with the last slot cycle.
    slot_last_o = (state_d == SHOW) && (cnt_d == SLOT_LAST);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= BLANK;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Double-buffered hex digit scanner driving a shared decoder; optional leading-zero
// blanking with DISPLAY_LZ_BLANK_EN.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int PRESCALE      = 50000,
  parameter int BLANK_CYCLES  = 16,
  parameter bit EN_ACTIVE_LOW = 1'b0
) (
  input logic                clk_i,
  input logic                rst_i,
  display_scan_ctrl_if.slave bus
);
  localparam int IW = idx_w(DIGITS);
  localparam logic [IW-1:0]     IDX_LAST = IW'(DIGITS - 1);
  localparam logic [DIGITS-1:0] EN_OFF   = EN_ACTIVE_LOW ? '1 : '0;

  typedef logic [DIGITS-1:0][3:0] hex_t;

  hex_t              val, p_q, p_d, s_q, s_d;
  logic              f_q, f_d, frame_q, frame_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [3:0]        cuenta_q, cuenta_d;
  logic [DIGITS-1:0] den_q, den_d, show_mask;
  logic              blank_end, slot_end, slot_last, boundary, xfer;

  assign val = bus.value_i;

  display_slot_timer #(
    .PRESCALE    (PRESCALE),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .en_i       (bus.en_i),
    .blank_end_o(blank_end),
    .slot_end_o (slot_end),
    .slot_last_o(slot_last)
  );

`ifdef DISPLAY_LZ_BLANK_EN
  always_comb begin
    logic acc;
    acc       = 1'b0;
    show_mask = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      acc          = acc | (|s_d[k]);
      show_mask[k] = acc;
    end
    show_mask[0] = 1'b1;
  end
`else
  assign show_mask = '1;
`endif

  always_comb begin
    boundary = slot_end && (idx_q == IDX_LAST);
    // Transfer reads P before any same-cycle load, so a boundary load waits a frame.
    xfer     = f_q && (boundary || !bus.en_i);
    p_d      = bus.load_i ? val : p_q;
    s_d      = xfer ? p_q : s_q;
    f_d      = bus.load_i | (f_q & ~xfer);
    idx_d    = idx_q;
    cuenta_d = cuenta_q;
    den_d    = den_q;
    if (!bus.en_i) begin
      idx_d    = '0;
      cuenta_d = s_d[0];
      den_d    = EN_OFF;
    end else if (slot_end) begin
      idx_d    = boundary ? '0 : idx_q + IW'(1);
      cuenta_d = s_d[idx_d];
      den_d    = EN_OFF;
    end else if (blank_end) begin
      den_d = ((DIGITS'(1) << idx_q) & show_mask) ^ EN_OFF;
    end
    frame_d = slot_last && (idx_d == IDX_LAST);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      p_q      <= '0;
      s_q      <= '0;
      f_q      <= 1'b0;
      idx_q    <= '0;
      cuenta_q <= '0;
      den_q    <= EN_OFF;
      frame_q  <= 1'b0;
    end else begin
      p_q      <= p_d;
      s_q      <= s_d;
      f_q      <= f_d;
      idx_q    <= idx_d;
      cuenta_q <= cuenta_d;
      den_q    <= den_d;
      frame_q  <= frame_d;
    end
  end

  assign bus.cuenta_o   = cuenta_q;
  assign bus.digit_en_o = den_q;
  assign bus.frame_o    = frame_q;
  assign bus.pending_o  = f_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: directed scenarios plus random traffic against a
// position-in-frame reference model.
module tb_display_scan_ctrl;
  localparam int D  = 4;
  localparam int PR = 20;
  localparam int BL = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  display_scan_ctrl_if #(.DIGITS(D)) bus ();

  display_scan_ctrl #(
    .DIGITS       (D),
    .PRESCALE     (PR),
    .BLANK_CYCLES (BL),
    .EN_ACTIVE_LOW(1'b0)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  int          checks = 0;
  int          fails  = 0;
  int          pos;
  logic [15:0] ms, mp;
  logic        mf;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s pos=%0d got=%h exp=%h", tag, pos, got, exp);
    end
  endtask

  function automatic logic [3:0] nib(input logic [15:0] v, input int k);
    return v[k*4 +: 4];
  endfunction

  function automatic logic [15:0] lzmask(input logic [15:0] v);
    logic [15:0] m;
    m = 16'h0;
`ifdef DISPLAY_LZ_BLANK_EN
    for (int k = 0; k < D; k++) m[k] = (k == 0) || ((v >> (4 * k)) != 16'h0);
`else
    m = 16'h000F;
`endif
    return m;
  endfunction

  task automatic model_reset();
    pos = 0;
    ms  = 16'h0;
    mp  = 16'h0;
    mf  = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_cuenta"},  {12'd0, bus.cuenta_o},   16'h0);
    chk({tag, "_den"},     {12'd0, bus.digit_en_o}, 16'h0);
    chk({tag, "_frame"},   {15'd0, bus.frame_o},    16'h0);
    chk({tag, "_pending"}, {15'd0, bus.pending_o},  16'h0);
  endtask

  // One clock: compare outputs for the current frame position, then advance the model.
  task automatic tick();
    int          slot, off;
    logic [15:0] exp_en;
    logic        bnd, xf;
    @(negedge clk);
    slot   = (pos / PR) % D;
    off    = pos % PR;
    exp_en = (off >= BL) ? ((16'd1 << slot) & lzmask(ms)) : 16'd0;
    chk("digit_en", {12'd0, bus.digit_en_o}, exp_en);
    chk("cuenta",   {12'd0, bus.cuenta_o},   {12'd0, nib(ms, slot)});
    chk("frame",    {15'd0, bus.frame_o},    16'((slot == D - 1) && (off == PR - 1)));
    chk("pending",  {15'd0, bus.pending_o},  16'(mf));
    bnd = bus.en_i && (slot == D - 1) && (off == PR - 1);
    xf  = mf && (bnd || !bus.en_i);
    if (xf) ms = mp;
    mf  = bus.load_i || (mf && !xf);
    if (bus.load_i) mp = bus.value_i;
    pos = bus.en_i ? (pos + 1) % (D * PR) : 0;
    @(posedge clk);
    #1;
  endtask

  task automatic load_val(input logic [15:0] v);
    bus.load_i  = 1'b1;
    bus.value_i = v;
    tick();
    bus.load_i  = 1'b0;
    bus.value_i = 16'($urandom);
  endtask

  task automatic run_to(input int target);
    for (int i = 0; i < 2 * D * PR && pos != target; i++) tick();
  endtask

  initial begin
    bus.en_i    = 1'b0;
    bus.load_i  = 1'b0;
    bus.value_i = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset("rst_init");
    rst      = 1'b0;
    bus.en_i = 1'b1;
    model_reset();

    // Empty display: blank gap, digit scan and frame pulse at cycle 79.
    repeat (D * PR) tick();

    // Mid-frame load appears at the next boundary.
    repeat (30) tick();
    load_val(16'hA3F5);
    repeat (2 * D * PR - 10) tick();

    // Last of two loads in a frame wins.
    run_to(10);
    load_val(16'h1111);
    repeat (20) tick();
    load_val(16'h2222);
    repeat (2 * D * PR - 10) tick();

    // Load in the boundary cycle waits one extra frame.
    run_to(D * PR - 1);
    load_val(16'h0042);
    repeat (2 * D * PR + 10) tick();

    // Disable mid-SHOW of digit 2, then restart from digit 0.
    run_to(2 * PR + 10);
    bus.en_i = 1'b0;
    repeat (5) tick();
    bus.en_i = 1'b1;
    repeat (D * PR + 20) tick();

    // Leading zeros (blanked only when the LZ feature is built in).
    load_val(16'h0070);
    repeat (2 * D * PR + 10) tick();

    // Asynchronous reset mid-slot coinciding with a load discards everything.
    run_to(PR + 7);
    bus.load_i  = 1'b1;
    bus.value_i = 16'hBEEF;
    rst         = 1'b1;
    #1;
    chk_reset("rst_mid");
    @(posedge clk);
    #1;
    rst        = 1'b0;
    bus.load_i = 1'b0;
    model_reset();
    repeat (D * PR + 5) tick();

    // Random enable/load traffic.
    for (int i = 0; i < 600; i++) begin
      bus.en_i    = ($urandom_range(0, 24) != 0);
      bus.load_i  = ($urandom_range(0, 29) == 0);
      bus.value_i = 16'($urandom);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
